// File: rtl/da_pkg.sv
// Shared types and width helpers for the distributed-arithmetic MAC engine.
// Imported by the partial-sum LUT and by the engine top level.
package da_pkg;

    // DCT cosine constant c4 in Q2.14.
    localparam int C4_Q14 = 11585;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUILD,
        ST_READY,
        ST_CALC,
        ST_DONE
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // A LUT entry holds the sum of up to NTAPS coefficients.
    function automatic int lut_width(input int cw, input int ntaps);
        return cw + clog2(ntaps);
    endfunction

    // The result adds XW bits of sample weight on top of a LUT entry.
    function automatic int out_width(input int cw, input int ntaps,
                                     input int xw);
        return cw + clog2(ntaps) + xw;
    endfunction

endpackage

// File: rtl/da_partial_sum_lut.sv
// Coefficient registers plus the 2^NTAPS partial-sum LUT and its builder.
// Entry k holds the sum of every coefficient whose index bit is set in k.
module da_partial_sum_lut
    import da_pkg::*;
#(
    parameter int NTAPS = 4,
    parameter int CW = 17,
    localparam int LOG2N = clog2(NTAPS),
    localparam int LW = lut_width(CW, NTAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coef_we,
    input  logic [LOG2N-1:0]        coef_idx,
    input  logic signed [CW-1:0]    coef_data,
    input  logic                    commit,
    input  logic [NTAPS-1:0]        rd_addr,
    output logic                    build_done,
    output logic signed [LW-1:0]    rd_data
);

    localparam int DEPTH = 1 << NTAPS;

    logic signed [CW-1:0] coef_q [NTAPS];
    logic signed [CW-1:0] coef_d [NTAPS];
    logic signed [LW-1:0] lut_q [DEPTH];
    logic signed [LW-1:0] lut_d [DEPTH];
    logic [NTAPS-1:0]     cnt_q, cnt_d;
    logic                 building_q, building_d;
    logic [LOG2N-1:0]     tz;
    logic [NTAPS-1:0]     src;
    logic signed [LW-1:0] wdata;

    assign build_done = building_q && (cnt_q == '1);
    assign rd_data = lut_q[rd_addr];

    // Coefficient register file write.
    always_comb begin
        coef_d = coef_q;
        if (coef_we) coef_d[coef_idx] = coef_data;
    end

    // New entry = earlier entry with lowest bit cleared + that bit's coef.
    always_comb begin
        tz = '0;
        for (int i = NTAPS - 1; i >= 0; i--) begin
            if (cnt_q[i]) tz = LOG2N'(i);
        end
        src = cnt_q & (cnt_q - NTAPS'(1));
        wdata = (cnt_q == '0) ? '0 : lut_q[src] + LW'(coef_q[tz]);
    end

    // Build sequencer: one entry per cycle, restarted by commit.
    always_comb begin
        building_d = building_q;
        cnt_d = cnt_q;
        lut_d = lut_q;
        if (commit) begin
            building_d = 1'b1;
            cnt_d = '0;
        end else if (building_q) begin
            lut_d[cnt_q] = wdata;
            cnt_d = cnt_q + NTAPS'(1);
            if (build_done) building_d = 1'b0;
        end
    end

    // Control and coefficient state, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            building_q <= 1'b0;
            cnt_q <= '0;
            for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
        end else begin
            building_q <= building_d;
            cnt_q <= cnt_d;
            coef_q <= coef_d;
        end
    end

    // LUT storage; contents are rebuilt after every commit.
    always_ff @(posedge clk) begin
        lut_q <= lut_d;
    end

endmodule

// File: rtl/da_mac_engine.sv
// Bit-serial distributed-arithmetic dot product, MSB first, exact width.
// Owns the sample handshake, sample shift registers and accumulator.
module da_mac_engine
    import da_pkg::*;
#(
    parameter int NTAPS = 4,
    parameter int XW = 16,
    parameter int CW = 17,
    localparam int LOG2N = clog2(NTAPS),
    localparam int LW = lut_width(CW, NTAPS),
    localparam int OW = out_width(CW, NTAPS, XW)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coef_we,
    input  logic [LOG2N-1:0]        coef_idx,
    input  logic signed [CW-1:0]    coef_data,
    input  logic                    coef_commit,
    output logic                    coef_err,
    output logic                    lut_ready,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NTAPS*XW-1:0]     in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OW-1:0]    out_data,
    output logic                    busy
);

    localparam int BW = clog2(XW);

    state_e               state_q, state_d;
    logic [XW-1:0]        x_q [NTAPS];
    logic [XW-1:0]        x_d [NTAPS];
    logic [BW-1:0]        bit_q, bit_d;
    logic signed [OW-1:0] acc_q, acc_d;
    logic signed [OW-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 coef_err_q, coef_err_d;
    logic                 wr_ok, lut_we, lut_commit, build_done;
    logic [NTAPS-1:0]     rd_addr;
    logic signed [LW-1:0] rd_data;
    logic signed [OW-1:0] term;

    assign wr_ok = (state_q == ST_IDLE) || (state_q == ST_READY);
    assign lut_we = coef_we && wr_ok;
    assign lut_commit = coef_commit && wr_ok;
    assign term = OW'(rd_data);

    assign in_ready = (state_q == ST_READY);
    assign lut_ready = (state_q == ST_READY);
    assign busy = (state_q == ST_BUILD) || (state_q == ST_CALC) ||
                  (state_q == ST_DONE);
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign coef_err = coef_err_q;

    da_partial_sum_lut #(
        .NTAPS(NTAPS),
        .CW(CW)
    ) u_lut (
        .clk(clk),
        .rst(rst),
        .coef_we(lut_we),
        .coef_idx(coef_idx),
        .coef_data(coef_data),
        .commit(lut_commit),
        .rd_addr(rd_addr),
        .build_done(build_done),
        .rd_data(rd_data)
    );

    // LUT address is the current MSB of every sample.
    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < NTAPS; i++) rd_addr[i] = x_q[i][XW-1];
    end

    // Engine sequencing, sample shifting and accumulation.
    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        x_d = x_q;
        acc_d = acc_q;
        out_valid_d = out_valid_q;
        out_data_d = out_data_q;
        coef_err_d = (coef_we || coef_commit) && !wr_ok;
        unique case (state_q)
            ST_IDLE: begin
                if (lut_commit) state_d = ST_BUILD;
            end
            ST_BUILD: begin
                if (build_done) state_d = ST_READY;
            end
            ST_READY: begin
                // A coefficient change wins over a sample offered with it.
                if (lut_commit) begin
                    state_d = ST_BUILD;
                end else if (lut_we) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    state_d = ST_CALC;
                    bit_d = '0;
                    for (int i = 0; i < NTAPS; i++) begin
                        x_d[i] = in_data[i*XW +: XW];
                    end
                end
            end
            ST_CALC: begin
                for (int i = 0; i < NTAPS; i++) x_d[i] = x_q[i] << 1;
                // The MSB carries negative weight in two's complement.
                acc_d = (bit_q == '0) ? -term : (acc_q <<< 1) + term;
                bit_d = bit_q + BW'(1);
                if (bit_q == BW'(XW - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d = acc_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q <= '0;
            acc_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            acc_q <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            coef_err_q <= coef_err_d;
            x_q <= x_d;
        end
    end

endmodule

// File: tb/tb_da_mac_engine.sv
// Directed and randomized bench for da_mac_engine.
// Expected results come from a plain integer dot-product model.
module tb_da_mac_engine;

    localparam int NTAPS = 4;
    localparam int XW = 16;
    localparam int CW = 17;
    localparam int OW = 35;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 coef_we;
    logic [1:0]           coef_idx;
    logic [CW-1:0]        coef_data;
    logic                 coef_commit;
    logic                 coef_err;
    logic                 lut_ready;
    logic                 in_valid;
    logic                 in_ready;
    logic [NTAPS*XW-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OW-1:0]        out_data;
    logic                 busy;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int c_m [NTAPS];

    always #5 clk = ~clk;

    da_mac_engine #(
        .NTAPS(NTAPS),
        .XW(XW),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .coef_we(coef_we),
        .coef_idx(coef_idx),
        .coef_data(coef_data),
        .coef_commit(coef_commit),
        .coef_err(coef_err),
        .lut_ready(lut_ready),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d want %0d", tag, got, exp);
    endtask

    function automatic longint dot(input int x [NTAPS]);
        longint s;
        s = 0;
        for (int i = 0; i < NTAPS; i++) begin
            s += longint'(c_m[i]) * longint'(x[i]);
        end
        return s;
    endfunction

    function automatic int rand_c();
        return int'($urandom_range(131071, 0)) - 65536;
    endfunction

    function automatic int rand_x();
        return int'($urandom_range(65535, 0)) - 32768;
    endfunction

    task automatic wr(input int idx, input int val, input bit cm);
        coef_we = 1'b1;
        coef_idx = 2'(idx);
        coef_data = 17'(val);
        coef_commit = cm;
        tick();
        coef_we = 1'b0;
        coef_commit = 1'b0;
    endtask

    task automatic wait_lut(input string tag);
        int n;
        n = 0;
        while (!lut_ready && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_build_lat"}, n, 16);
    endtask

    // Last coefficient is written in the same cycle as the commit.
    task automatic load(input int c [NTAPS], input string tag);
        for (int i = 0; i < NTAPS; i++) begin
            wr(i, c[i], i == NTAPS - 1);
            c_m[i] = c[i];
        end
        wait_lut(tag);
    endtask

    task automatic send(input int x [NTAPS]);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("send_in_ready", in_ready, 1);
        in_valid = 1'b1;
        for (int i = 0; i < NTAPS; i++) in_data[i*XW +: XW] = 16'(x[i]);
        tick();
        acc_cyc = cyc;
        in_valid = 1'b0;
        in_data = {$urandom(), $urandom()};
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic recv(input longint exp, input string tag);
        wait_out();
        chk({tag, "_lat"}, cyc - acc_cyc, XW + 1);
        chk({tag, "_data"}, longint'($signed(out_data)), exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ovclr"}, out_valid, 0);
        chk({tag, "_irdy"}, in_ready, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_od"}, longint'($signed(out_data)), 0);
        chk({tag, "_lr"}, lut_ready, 0);
        chk({tag, "_ir"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, coef_err, 0);
    endtask

    initial begin
        int cf [NTAPS];
        int x [NTAPS];
        int x2 [NTAPS];
        longint e;
        int seen_ov;
        int seen_ir;
        rst = 1'b1;
        coef_we = 1'b0;
        coef_commit = 1'b0;
        coef_idx = '0;
        coef_data = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // c4 on every tap, unit samples.
        cf = '{11585, 11585, 11585, 11585};
        load(cf, "c4");
        x = '{1, 1, 1, 1};
        send(x);
        chk("calc_busy", busy, 1);
        chk("calc_irdy", in_ready, 0);
        recv(46340, "c4_ones");

        // Single tap, sign-bit handling.
        cf = '{11585, 0, 0, 0};
        load(cf, "single");
        x = '{-1, 0, 0, 0};
        send(x);
        recv(-11585, "neg_one");
        x = '{-32768, 0, 0, 0};
        send(x);
        recv(-379617280, "min_x");

        // Both operands at their most negative value.
        cf = '{-65536, -65536, -65536, -65536};
        load(cf, "minc");
        x = '{-32768, -32768, -32768, -32768};
        send(x);
        recv(64'sd8589934592, "full_range");

        // Output held under back-pressure, then back-to-back vector.
        cf = '{11585, -11585, 6000, -3};
        load(cf, "hold");
        x = '{1234, -567, 32767, -32768};
        e = dot(x);
        send(x);
        wait_out();
        chk("hold_lat", cyc - acc_cyc, XW + 1);
        for (int k = 0; k < 5; k++) begin
            chk("hold_data", longint'($signed(out_data)), e);
            chk("hold_irdy", in_ready, 0);
            chk("hold_ov", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("xfer_irdy", in_ready, 1);
        chk("xfer_ovclr", out_valid, 0);
        chk("xfer_keep", longint'($signed(out_data)), e);
        for (int i = 0; i < NTAPS; i++) x2[i] = rand_x();
        send(x2);
        recv(dot(x2), "b2b");

        // Write during CALC is dropped and flagged.
        for (int i = 0; i < NTAPS; i++) x[i] = rand_x();
        e = dot(x);
        send(x);
        tick();
        tick();
        wr(0, 777, 1'b0);
        chk("err_pulse", coef_err, 1);
        tick();
        chk("err_clear", coef_err, 0);
        recv(e, "drop");

        // Write in READY invalidates the LUT until a rebuild.
        wr(1, -4000, 1'b0);
        c_m[1] = -4000;
        chk("rdy_wr_lr", lut_ready, 0);
        in_valid = 1'b1;
        tick();
        chk("rdy_wr_ir0", in_ready, 0);
        tick();
        chk("rdy_wr_ir1", in_ready, 0);
        in_valid = 1'b0;
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        wait_lut("rebuild");
        for (int i = 0; i < NTAPS; i++) x[i] = rand_x();
        send(x);
        recv(dot(x), "after_wr");

        // Reset in the middle of CALC aborts with no result.
        for (int i = 0; i < NTAPS; i++) x[i] = rand_x();
        send(x);
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        chk_zero("mid_rst");
        rst = 1'b0;
        for (int i = 0; i < NTAPS; i++) c_m[i] = 0;
        seen_ov = 0;
        seen_ir = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid) seen_ov++;
            if (in_ready) seen_ir++;
        end
        chk("rst_no_ov", seen_ov, 0);
        chk("rst_no_ir", seen_ir, 0);

        // Randomized coefficient sets and samples.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NTAPS; i++) cf[i] = rand_c();
            load(cf, "rnd");
            for (int v = 0; v < 3; v++) begin
                for (int i = 0; i < NTAPS; i++) x[i] = rand_x();
                send(x);
                recv(dot(x), "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
